sort_unloader: RTL and testbench
================================

Name: sort_unloader

Overview:
- Downstream stage of the bitonic sort network.
- Captures each sorted batch of 2**LOG_INPUT words, presented as one flattened vector on the network's y/y_valid outputs.
- Streams the batch out one word per cycle over a valid/ready interface, flagging the last word of each batch.
- Two-slot ping-pong buffer absorbs a new batch while the previous one drains; the sort network has no backpressure, so batches arriving with both slots full are dropped and flagged.

Parameters:
- LOG_INPUT, 5, log2 of words per batch; N = 2**LOG_INPUT.
- DATA_WIDTH, 32, bits per word.
- ASCENDING_OUT, 1; 1 = emit word index 0 first, 0 = emit index N-1 first.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  connect to sort y_valid; single-cycle batch strobe.
- in_data  in  DATA_WIDTH*N  connect to sort y; word i = in_data[DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  consumer accepts the word this cycle.
- out_data  out  DATA_WIDTH  current word.
- out_index  out  LOG_INPUT  position of the current word in the batch (0..N-1).
- out_last  out  1  current word is the final word emitted for this batch.
- overflow  out  1  sticky; set when a batch was dropped.
- busy  out  1  at least one batch is held (count != 0).

Behaviour:
- Storage:
  - slot[0], slot[1], each DATA_WIDTH*N.
  - wr_ptr, rd_ptr: 1 bit each.
  - count: 0..2.
  - idx: LOG_INPUT bits, emission counter.
- Reset (rst=1 at an edge):
  - count=0, wr_ptr=0, rd_ptr=0, idx=0, overflow=0.
  - Outputs then read out_valid=0, out_last=0, busy=0, out_index=0, out_data=0.
  - Slot contents need not be cleared.
  - Reset mid-drain discards both slots; no word is emitted after reset.
  - in_valid during the reset cycle is ignored.
- Handshake:
  - Word transfer when out_valid && out_ready at the rising edge.
  - While out_valid=1 and out_ready=0, out_data, out_index and out_last hold stable.
  - out_valid never drops without a transfer, except on reset.
- Outputs are decoded from registers, with no combinational path from in_*:
  - out_valid = (count != 0).
  - out_index = idx when ASCENDING_OUT=1, else N-1-idx.
  - out_data = word[out_index] of slot[rd_ptr] when valid, else 0.
  - out_last = out_valid && (idx == N-1).
- Capture rules:
  - On in_valid with count<2: slot[wr_ptr] <= in_data, wr_ptr toggles.
  - On in_valid with count==2 and a final-word transfer in the same cycle: capture is also accepted, since the freed slot is the one wr_ptr points to.
  - On in_valid with count==2 and no final transfer: batch dropped, overflow <= 1. overflow is cleared only by rst.
- Drain rules:
  - Each transfer increments idx.
  - On a transfer with idx==N-1: idx wraps to 0, rd_ptr toggles, count decrements.
- Count update:
  - +1 on accepted capture.
  - -1 on final transfer.
  - Unchanged when both occur in the same cycle.
- Latency:
  - Batch strobed at edge k gives out_valid=1 in the cycle after edge k when count was 0.
  - First word emitted at edge k+1 if out_ready=1.
  - A batch needs N cycles minimum with out_ready held high.
- Back-to-back batches with continuous out_ready produce a gap-free output stream.
- Implied states: EMPTY (count 0), DRAIN1 (count 1), DRAIN2 (count 2). Transitions follow the count rules above.
- N=2 (LOG_INPUT=1) must work, including capture on the same cycle as out_last.

Test Plan:
- Single batch:
  - Stimulus: LOG_INPUT=2, DATA_WIDTH=32, in_data words {0x01,0x05,0x09,0x0F} (index 0..3), in_valid pulse, out_ready=1.
  - Required: out_data 0x01,0x05,0x09,0x0F on 4 consecutive cycles; out_index 0..3; out_last only on 0x0F; then out_valid=0, busy=0.
- Descending emission:
  - Stimulus: same batch with ASCENDING_OUT=0.
  - Required: out_data 0x0F,0x09,0x05,0x01; out_index 3,2,1,0; out_last on 0x01.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1,1,1 after a batch.
  - Required: out_data holds 0x05 through both stall cycles; exactly 4 transfers; no duplicated or skipped words.
- Overflow:
  - Stimulus: out_ready=0; three in_valid pulses with batches A, B, C.
  - Required: overflow=1 after C; then out_ready=1 yields A then B, 8 words; C never appears; overflow stays 1 until rst.
- Simultaneous event:
  - Stimulus: count=2; batch C strobed on the cycle of A's out_last transfer.
  - Required: C accepted, overflow stays 0; output order is A, B, C with no gaps.
- Reset mid-drain:
  - Stimulus: rst=1 after 2 of 4 words are emitted.
  - Required: next cycle out_valid=0, busy=0, out_index=0, overflow=0; a new batch afterwards emits from index 0.

Source files
------------

// File: rtl/sort_unloader.sv
// rtl/sort_unloader.sv - ping-pong buffered serializer for sorted batches from the bitonic network
module sort_unloader #(
  parameter int LOG_INPUT     = 5,
  parameter int DATA_WIDTH    = 32,
  parameter bit ASCENDING_OUT = 1'b1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  input  logic [DATA_WIDTH*(2**LOG_INPUT)-1:0]  in_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [DATA_WIDTH-1:0]                 out_data,
  output logic [LOG_INPUT-1:0]                  out_index,
  output logic                                  out_last,
  output logic                                  overflow,
  output logic                                  busy
);

  localparam int N = 2 ** LOG_INPUT;

  // Occupancy doubles as the FSM state: number of batches held.
  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    DRAIN1 = 2'd1,
    DRAIN2 = 2'd2
  } state_t;

  state_t                        r_state;
  logic                          r_wr_ptr;
  logic                          r_rd_ptr;
  logic                          r_overflow;
  logic [LOG_INPUT-1:0]          r_idx;
  logic [DATA_WIDTH*N-1:0]       r_slot [2];

  logic                          w_valid;
  logic                          w_xfer;
  logic                          w_final;
  logic                          w_accept;
  logic [LOG_INPUT-1:0]          w_index;
  logic [DATA_WIDTH*N-1:0]       w_rd_slot;
  logic [DATA_WIDTH-1:0]         w_words [N];

  assign w_valid  = (r_state != EMPTY);
  assign w_xfer   = w_valid && out_ready;
  assign w_final  = w_xfer && (&r_idx);
  // When full, the slot freed by a final transfer is exactly the one wr_ptr points at.
  assign w_accept = in_valid && ((r_state != DRAIN2) || w_final);

  // Batch storage; contents are don't-care until captured, so no reset.
  always_ff @(posedge clk) begin
    if (!rst && w_accept) begin
      r_slot[r_wr_ptr] <= in_data;
    end
  end

  // Pointers, emission counter, occupancy state and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= EMPTY;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_idx      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (in_valid && !w_accept) begin
        r_overflow <= 1'b1;
      end
      if (w_xfer) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_final) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_accept, w_final})
        2'b10: begin
          case (r_state)
            EMPTY:   r_state <= DRAIN1;
            DRAIN1:  r_state <= DRAIN2;
            default: r_state <= r_state;
          endcase
        end
        2'b01: begin
          case (r_state)
            DRAIN2:  r_state <= DRAIN1;
            DRAIN1:  r_state <= EMPTY;
            default: r_state <= r_state;
          endcase
        end
        default: r_state <= r_state;
      endcase
    end
  end

  // Unpack the draining slot into words for indexed selection.
  always_comb begin
    w_rd_slot = r_slot[r_rd_ptr];
    for (int i = 0; i < N; i++) begin
      w_words[i] = w_rd_slot[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Emission order: descending is the bitwise complement of the counter (N-1-idx).
  always_comb begin
    w_index = '0;
    if (w_valid) begin
      w_index = ASCENDING_OUT ? r_idx : ~r_idx;
    end
  end

  assign out_valid = w_valid;
  assign out_index = w_index;
  assign out_data  = w_valid ? w_words[w_index] : '0;
  assign out_last  = w_valid && (&r_idx);
  assign overflow  = r_overflow;
  assign busy      = w_valid;

endmodule

// File: tb/tb_sort_unloader.sv
// tb/tb_sort_unloader.sv - directed self-checking bench for sort_unloader
module tb_sort_unloader;

  localparam int LOG_INPUT = 2;
  localparam int DW        = 32;
  localparam int N         = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DW*N-1:0]   in_data;
  logic              out_ready;

  logic              a_valid, a_last, a_ovf, a_busy;
  logic [DW-1:0]     a_data;
  logic [1:0]        a_index;
  logic              d_valid, d_last, d_ovf, d_busy;
  logic [DW-1:0]     d_data;
  logic [1:0]        d_index;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sort_unloader #(.LOG_INPUT(LOG_INPUT), .DATA_WIDTH(DW), .ASCENDING_OUT(1'b1)) u_asc (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(a_valid), .out_ready(out_ready), .out_data(a_data),
    .out_index(a_index), .out_last(a_last), .overflow(a_ovf), .busy(a_busy)
  );

  sort_unloader #(.LOG_INPUT(LOG_INPUT), .DATA_WIDTH(DW), .ASCENDING_OUT(1'b0)) u_desc (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(d_valid), .out_ready(out_ready), .out_data(d_data),
    .out_index(d_index), .out_last(d_last), .overflow(d_ovf), .busy(d_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW*N-1:0] pack(input logic [7:0] base);
    logic [DW*N-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = 32'(base + 8'(i));
    return v;
  endfunction

  logic [31:0] sb_words [4];
  logic [31:0] exp_q [$];
  logic [31:0] got_q [$];
  logic        bp_pat [6];

  initial begin
    sb_words[0] = 32'h01; sb_words[1] = 32'h05; sb_words[2] = 32'h09; sb_words[3] = 32'h0F;
    bp_pat[0] = 1'b1; bp_pat[1] = 1'b0; bp_pat[2] = 1'b0;
    bp_pat[3] = 1'b1; bp_pat[4] = 1'b1; bp_pat[5] = 1'b1;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_index", 32'(a_index), 32'd0);
    chk("rst_index_desc", 32'(d_index), 32'd0);
    chk("rst_data", a_data, 32'd0);
    chk("rst_last", 32'(a_last), 32'd0);
    chk("rst_ovf", 32'(a_ovf), 32'd0);

    // Single batch, both emission orders
    in_data = {sb_words[3], sb_words[2], sb_words[1], sb_words[0]};
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk("sb_valid", 32'(a_valid), 32'd1);
      chk("sb_data", a_data, sb_words[i]);
      chk("sb_index", 32'(a_index), 32'(i));
      chk("sb_last", 32'(a_last), 32'(i == 3));
      chk("desc_data", d_data, sb_words[3-i]);
      chk("desc_index", 32'(d_index), 32'(3 - i));
      chk("desc_last", 32'(d_last), 32'(i == 3));
      step();
    end
    chk("sb_end_valid", 32'(a_valid), 32'd0);
    chk("sb_end_busy", 32'(a_busy), 32'd0);

    // Backpressure
    in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    got_q.delete();
    for (int j = 0; j < 6; j++) begin
      out_ready = bp_pat[j];
      if (!bp_pat[j]) begin
        chk("bp_hold_data", a_data, 32'h05);
        chk("bp_hold_index", 32'(a_index), 32'd1);
      end
      if (a_valid && out_ready) got_q.push_back(a_data);
      step();
    end
    chk("bp_xfers", 32'(got_q.size()), 32'd4);
    for (int j = 0; j < 4; j++) begin
      if (j < got_q.size()) chk("bp_word", got_q[j], sb_words[j]);
    end
    chk("bp_end_valid", 32'(a_valid), 32'd0);

    // Overflow: A, B, C with consumer stalled
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = pack(8'hA0); step();
    in_data = pack(8'hB0); step();
    chk("ovf_before_c", 32'(a_ovf), 32'd0);
    in_data = pack(8'hC0); step();
    in_valid = 1'b0;
    chk("ovf_set", 32'(a_ovf), 32'd1);
    chk("ovf_set_desc", 32'(d_ovf), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ovf_valid", 32'(a_valid), 32'd1);
      chk("ovf_data", a_data, (i < 4) ? 32'(8'hA0 + 8'(i)) : 32'(8'hB0 + 8'(i - 4)));
      chk("ovf_last", 32'(a_last), 32'(i == 3 || i == 7));
      step();
    end
    chk("ovf_no_c", 32'(a_valid), 32'd0);
    chk("ovf_sticky", 32'(a_ovf), 32'd1);
    step();
    chk("ovf_sticky2", 32'(a_ovf), 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("ovf_cleared", 32'(a_ovf), 32'd0);

    // Simultaneous capture on A's final transfer while full
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = pack(8'hA0); step();
    in_data = pack(8'hB0); step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(8'hA0 + 8'(i)));
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(8'hB0 + 8'(i)));
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(8'hC0 + 8'(i)));
    for (int i = 0; i < 12; i++) begin
      if (i == 3) begin
        chk("sim_a_last", 32'(a_last), 32'd1);
        in_valid = 1'b1; in_data = pack(8'hC0);
      end else begin
        in_valid = 1'b0;
      end
      chk("sim_valid", 32'(a_valid), 32'd1);
      chk("sim_data", a_data, exp_q[i]);
      step();
    end
    in_valid = 1'b0;
    chk("sim_ovf", 32'(a_ovf), 32'd0);
    chk("sim_end_valid", 32'(a_valid), 32'd0);

    // Reset mid-drain
    in_valid = 1'b1; in_data = pack(8'hA0); out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    chk("mid_before_rst", a_data, 32'hA2);
    rst = 1'b1; in_valid = 1'b1; in_data = pack(8'hC0);
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk("mid_valid", 32'(a_valid), 32'd0);
    chk("mid_busy", 32'(a_busy), 32'd0);
    chk("mid_index", 32'(a_index), 32'd0);
    chk("mid_index_desc", 32'(d_index), 32'd0);
    chk("mid_ovf", 32'(a_ovf), 32'd0);
    step();
    chk("mid_still_idle", 32'(a_valid), 32'd0);
    in_valid = 1'b1; in_data = pack(8'hB0);
    step();
    in_valid = 1'b0;
    chk("mid_new_index", 32'(a_index), 32'd0);
    chk("mid_new_data", a_data, 32'hB0);
    chk("mid_new_desc", d_data, 32'hB3);
    step();
    chk("mid_new_next", a_data, 32'hB1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
